uart_tx: RTL and testbench

UART transmitter: pulls words from an upstream first-word-fall-through FIFO and serialises each one onto a single line as an 8N1-style frame (start, data LSB first, optional parity, stop). It is the transmit counterpart to `uart_rx`, with a read-side handshake (`empty`/`re`) that mirrors the receiver's write-side handshake (`full`/`we`). It sits between status/echo logic and the board TX pin, at the same baud settings as the receive path.

---
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: pulls words from a first-word-fall-through FIFO and sends start, data (LSB first), stop.
// Define UART_TX_PARITY_EN to add an even-parity bit between the last data bit and the stop bit.
`timescale 1ns/1ps

module uart_tx #(
    parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
    parameter int unsigned BAUD_RATE       = 32'd115200,
    parameter int unsigned WORD_WIDTH      = 32'd8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  empty,
    output logic                  re,
    output logic                  dout,
    output logic                  busy
);

    // DIV truncates; it must come out at 2 or more for the baud counter to make sense.
    localparam int unsigned DIV    = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [WORD_WIDTH-1:0] r_shift;
    logic                  r_dout;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    state_t                w_next_state;
    logic                  w_re;
    logic                  w_baud_done;
    logic                  w_last_bit;
    logic [WORD_WIDTH-1:0] w_shift_next;
    logic                  w_dout_next;

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);
    assign w_last_bit  = (r_bit_cnt == BIT_LAST);

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_re         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!empty) begin
                    w_re         = 1'b1;
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) w_next_state = S_DATA;
            end
            S_DATA: begin
                if (w_baud_done && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) w_next_state = S_STOP;
            end
`endif
            S_STOP: begin
                // Fetching the next word in the last stop cycle chains frames with no idle gap.
                if (w_baud_done) begin
                    if (!empty) begin
                        w_re         = 1'b1;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (!rst) begin
            w_re         = 1'b0;
            w_next_state = S_IDLE;
        end
    end

    always_comb begin
        w_shift_next = r_shift;
        if (w_re) begin
            w_shift_next = din;
        end else if (r_state == S_DATA && w_baud_done) begin
            w_shift_next = r_shift >> 1;
        end
    end

    // The line level is computed for the state being entered so dout comes straight from a flop.
    always_comb begin
        w_dout_next = 1'b1;
        case (w_next_state)
            S_START:  w_dout_next = 1'b0;
            S_DATA:   w_dout_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_dout_next = r_parity;
`endif
            default:  w_dout_next = 1'b1;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_dout     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_shift <= w_shift_next;
            r_dout  <= w_dout_next;
`ifdef UART_TX_PARITY_EN
            if (w_re) r_parity <= ^din;
`endif
            if (r_state == S_IDLE || w_next_state != r_state || w_baud_done) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_baud_done) begin
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

    assign re   = w_re;
    assign dout = r_dout;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks for uart_tx at DIV=16, including chaining, reset and parity.
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int unsigned CLK_HZ = 16;
    localparam int unsigned BAUD   = 1;
    localparam int unsigned WW     = 8;
    localparam int          DIV    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int          NSLOT    = 11;
    localparam int          PAR_SLOT = 9;
`else
    localparam int          NSLOT    = 10;
    localparam int          PAR_SLOT = -1;
`endif

    // exp_bits is written in line order: bit [7] is the first data bit on the wire.
    typedef struct packed {
        logic [7:0] din;
        logic [7:0] mid_din;
        logic [7:0] exp_bits;
        logic       exp_par;
        logic       b2b;
        logic       chain;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] din   = 8'h00;
    logic       re;
    logic       dout;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl [7];

    always #5 clk = ~clk;

    uart_tx #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE      (BAUD),
        .WORD_WIDTH     (WW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .empty(empty),
        .re   (re),
        .dout (dout),
        .busy (busy)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic e_dout, input logic e_busy, input logic e_re);
        #1;
        check({name, ".dout"}, dout, e_dout);
        check({name, ".busy"}, busy, e_busy);
        check({name, ".re"},   re,   e_re);
    endtask

    // Called in the first start-bit cycle; returns in the cycle right after the stop bit.
    task automatic expect_frame(input logic [7:0] exp_bits, input logic exp_par, input logic tail_re);
        logic lv;
        for (int s = 0; s < NSLOT; s++) begin
            if (s == 0)             lv = 1'b0;
            else if (s <= 8)        lv = exp_bits[8-s];
            else if (s == PAR_SLOT) lv = exp_par;
            else                    lv = 1'b1;
            for (int c = 0; c < DIV; c++) begin
                check_outs($sformatf("slot%0d.c%0d", s, c), lv, 1'b1,
                           (s == NSLOT-1 && c == DIV-1) ? tail_re : 1'b0);
                step();
            end
        end
    endtask

    initial begin
        tbl[0] = '{din:8'h55, mid_din:8'h55, exp_bits:8'b10101010, exp_par:1'b0, b2b:1'b0, chain:1'b0};
        tbl[1] = '{din:8'hA5, mid_din:8'h3C, exp_bits:8'b10100101, exp_par:1'b0, b2b:1'b1, chain:1'b0};
        tbl[2] = '{din:8'h3C, mid_din:8'hF0, exp_bits:8'b00111100, exp_par:1'b0, b2b:1'b0, chain:1'b1};
        tbl[3] = '{din:8'h0F, mid_din:8'hF0, exp_bits:8'b11110000, exp_par:1'b0, b2b:1'b0, chain:1'b0};
        tbl[4] = '{din:8'h07, mid_din:8'h00, exp_bits:8'b11100000, exp_par:1'b1, b2b:1'b0, chain:1'b0};
        tbl[5] = '{din:8'h03, mid_din:8'hFF, exp_bits:8'b11000000, exp_par:1'b0, b2b:1'b0, chain:1'b0};
        tbl[6] = '{din:8'h80, mid_din:8'h7F, exp_bits:8'b00000001, exp_par:1'b1, b2b:1'b0, chain:1'b0};

        // Reset held with a non-empty FIFO: no read, line idle.
        rst   = 1'b0;
        empty = 1'b0;
        din   = 8'hAA;
        step();
        for (int i = 0; i < 3; i++) begin
            check_outs("reset", 1'b1, 1'b0, 1'b0);
            step();
        end
        rst   = 1'b1;
        empty = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_outs("idle", 1'b1, 1'b0, 1'b0);
            step();
        end

        for (int v = 0; v < 7; v++) begin
            if (!tbl[v].chain) begin
                din   = tbl[v].din;
                empty = 1'b0;
                check_outs($sformatf("v%0d.kick", v), 1'b1, 1'b0, 1'b1);
                step();
            end
            // Changing din and holding empty low mid-frame must not disturb the frame.
            din   = tbl[v].mid_din;
            empty = tbl[v].b2b ? 1'b0 : 1'b1;
            expect_frame(tbl[v].exp_bits, tbl[v].exp_par, tbl[v].b2b);
            if (!tbl[v].b2b) begin
                for (int i = 0; i < 3; i++) begin
                    check_outs($sformatf("v%0d.post%0d", v, i), 1'b1, 1'b0, 1'b0);
                    step();
                end
            end
        end

        // Reset in the middle of data bit 3, then a fresh frame after release.
        din   = 8'hC3;
        empty = 1'b0;
        check_outs("rmf.kick", 1'b1, 1'b0, 1'b1);
        step();
        for (int i = 0; i < DIV + 3*DIV + 8; i++) step();
        check_outs("rmf.bit3", 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check("rmf.re_gated", re, 1'b0);
        step();
        check_outs("rmf.after_rst", 1'b1, 1'b0, 1'b0);
        step();
        rst   = 1'b1;
        din   = 8'h5A;
        empty = 1'b0;
        check_outs("rmf.rekick", 1'b1, 1'b0, 1'b1);
        step();
        din   = 8'h00;
        empty = 1'b1;
        expect_frame(8'b01011010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_outs($sformatf("rmf.post%0d", i), 1'b1, 1'b0, 1'b0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
